// File: rtl/doodle_pkg.sv
// Shared screen geometry, start position and state encodings for the doodle
// motion path and the game state machine.
package doodle_pkg;
    localparam int SCR_X_MIN     = 144;
    localparam int SCR_X_MAX     = 774;
    localparam int SCR_Y_MIN     = 35;
    localparam int SCR_Y_MAX     = 515;
    localparam int DOODLE_RADIUS = 13;
    localparam int POS_SAT       = 1023;

    localparam logic [15:0] START_X = 16'd288;
    localparam logic [15:0] START_Y = 16'd458;
    localparam logic [15:0] Y_TOP   = 16'(SCR_Y_MIN + DOODLE_RADIUS);

    // {q_Done, q_Down, q_Up, q_I}
    typedef enum logic [3:0] {
        ST_I    = 4'b0001,
        ST_UP   = 4'b0010,
        ST_DOWN = 4'b0100,
        ST_DONE = 4'b1000
    } game_state_e;

    // Rise speed slows as the apex nears; zero once the apex is reached.
    function automatic logic [3:0] rise_speed(input logic [9:0] jh, input logic [9:0] uc);
        logic [9:0] rem;
        rem = jh - uc;
        if (uc >= jh)       return 4'd0;
        else if (rem >= 32) return 4'd4;
        else if (rem >= 8)  return 4'd2;
        else                return 4'd1;
    endfunction
endpackage

// File: rtl/doodle_motion_if.sv
// Motion interface between the game state machine (master) and the doodle
// motion generator (slave).
interface doodle_motion_if;
    logic        q_I, q_Up, q_Down, q_Done;
    logic        is_in_middle;
    logic [9:0]  JUMP_HEIGHT;
    logic        btn_left, btn_right;
    logic [15:0] object_x, object_y;
    logic [9:0]  up_count;
    logic [3:0]  vert_speed;
    logic        frame_tick;

    modport master (
        output q_I, q_Up, q_Down, q_Done, is_in_middle, JUMP_HEIGHT, btn_left, btn_right,
        input  object_x, object_y, up_count, vert_speed, frame_tick
    );
    modport slave (
        input  q_I, q_Up, q_Down, q_Done, is_in_middle, JUMP_HEIGHT, btn_left, btn_right,
        output object_x, object_y, up_count, vert_speed, frame_tick
    );
endinterface

// File: rtl/doodle_tick_gen.sv
// Frame divider: one-cycle frame_tick each time the counter wraps to 0.
module doodle_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic Clk,
    input  logic Reset,
    output logic frame_tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt    <= '0;
            frame_tick <= 1'b1;
        end else begin
            div_cnt    <= div_cnt + 1'b1;
            frame_tick <= 1'b0;
        end
    end
endmodule

// File: rtl/doodle_motion.sv
// Doodle physics: jump rise, accelerating fall and wrap-around horizontal
// motion, advanced once per frame tick.
module doodle_motion
    import doodle_pkg::*;
#(
    parameter int TICK_DIV       = 833333,
    parameter int H_STEP         = 3,
    parameter int MAX_FALL       = 6,
    parameter int FALL_ACC_TICKS = 8
) (
    input logic            Clk,
    input logic            Reset,
    doodle_motion_if.slave m
);
    localparam int             FCW       = (FALL_ACC_TICKS > 1) ? $clog2(FALL_ACC_TICKS) : 1;
    localparam logic [FCW-1:0] FALL_LAST = FCW'(FALL_ACC_TICKS - 1);
    localparam logic [3:0]     SPD_MAX   = 4'(MAX_FALL);

    logic           tick;
    logic [15:0]    obj_x, obj_y, x_next;
    logic [9:0]     up_cnt;
    logic [3:0]     vspd, rise;
    logic [FCW-1:0] fall_cnt;
    logic           prev_up, prev_down;
    logic [3:0]     st;
    logic [10:0]    up_sum;
    logic [16:0]    y_fall;

    doodle_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (tick)
    );

    assign m.frame_tick = tick;
    assign m.object_x   = obj_x;
    assign m.object_y   = obj_y;
    assign m.up_count   = up_cnt;
    assign m.vert_speed = vspd;

    assign st     = {m.q_Done, m.q_Down, m.q_Up, m.q_I};
    assign rise   = rise_speed(m.JUMP_HEIGHT, up_cnt);
    assign up_sum = {1'b0, up_cnt} + 11'(rise);
    assign y_fall = {1'b0, obj_y} + 17'(vspd);

    // Leaving one screen edge re-enters at the other; both buttons cancel.
    always_comb begin
        x_next = obj_x;
        if (m.btn_left && !m.btn_right)
            x_next = (obj_x < 16'(SCR_X_MIN + H_STEP)) ? 16'(SCR_X_MAX) : obj_x - 16'(H_STEP);
        else if (m.btn_right && !m.btn_left)
            x_next = (obj_x + 16'(H_STEP) > 16'(SCR_X_MAX)) ? 16'(SCR_X_MIN) : obj_x + 16'(H_STEP);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            obj_x     <= START_X;
            obj_y     <= START_Y;
            up_cnt    <= '0;
            vspd      <= '0;
            fall_cnt  <= '0;
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
        end else begin
            prev_up   <= m.q_Up;
            prev_down <= m.q_Down;
            case (st)
                ST_I: begin
                    obj_x  <= START_X;
                    obj_y  <= START_Y;
                    up_cnt <= '0;
                    vspd   <= '0;
                end
                // State entry takes priority over a coincident tick.
                ST_UP:
                    if (!prev_up) begin
                        up_cnt <= '0;
                        vspd   <= rise_speed(m.JUMP_HEIGHT, 10'd0);
                    end else if (tick) begin
                        obj_x  <= x_next;
                        vspd   <= rise;
                        up_cnt <= (up_sum > 11'(POS_SAT)) ? 10'(POS_SAT) : up_sum[9:0];
                        if (!m.is_in_middle)
                            obj_y <= (obj_y < Y_TOP + 16'(rise)) ? Y_TOP : obj_y - 16'(rise);
                    end
                ST_DOWN:
                    if (!prev_down) begin
                        vspd     <= 4'd1;
                        fall_cnt <= '0;
                    end else if (tick) begin
                        obj_x <= x_next;
                        obj_y <= (y_fall > 17'(POS_SAT)) ? 16'(POS_SAT) : y_fall[15:0];
                        if (fall_cnt == FALL_LAST) begin
                            fall_cnt <= '0;
                            vspd     <= (vspd >= SPD_MAX) ? SPD_MAX : vspd + 4'd1;
                        end else begin
                            fall_cnt <= fall_cnt + 1'b1;
                        end
                    end
                default: ;  // DONE and non-one-hot states hold everything
            endcase
        end
    end
endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion with a 4-cycle frame divider.
module tb_doodle_motion;
    logic Clk = 1'b0;
    logic Reset;
    int   n_chk = 0;
    int   n_fail = 0;

    doodle_motion_if dif ();

    doodle_motion #(.TICK_DIV(4), .H_STEP(3), .MAX_FALL(6), .FALL_ACC_TICKS(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .m     (dif)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_st(input logic [3:0] s);
        {dif.q_Done, dif.q_Down, dif.q_Up, dif.q_I} = s;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int up, input int vs);
        chk({tag, "_x"},  32'(dif.object_x),   32'(x));
        chk({tag, "_y"},  32'(dif.object_y),   32'(y));
        chk({tag, "_up"}, 32'(dif.up_count),   32'(up));
        chk({tag, "_vs"}, 32'(dif.vert_speed), 32'(vs));
    endtask

    // Wait for a frame tick, then one more cycle so its result is visible.
    task automatic next_tick();
        int k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!dif.frame_tick && k < 20);
        chk("tick_seen", 32'(dif.frame_tick), 32'd1);
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) next_tick();
    endtask

    initial begin
        int first = 0;
        int nt = 0;
        Reset = 1'b1;
        set_st(4'b0001);
        dif.is_in_middle = 1'b0;
        dif.JUMP_HEIGHT  = 10'd40;
        dif.btn_left     = 1'b0;
        dif.btn_right    = 1'b0;
        repeat (2) @(negedge Clk);
        chk_pos("rst", 288, 458, 0, 0);
        chk("rst_tick", 32'(dif.frame_tick), 32'd0);

        Reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            if (dif.frame_tick) begin
                nt++;
                if (first == 0) first = c;
            end
        end
        chk("first_tick", 32'(first), 32'd4);
        chk("tick_count", 32'(nt), 32'd3);

        // UP entry on the same edge as a tick: no motion
        set_st(4'b0010);
        @(negedge Clk);
        chk_pos("up_entry", 288, 458, 0, 4);
        ticks(1);
        chk_pos("up_t1", 288, 454, 4, 4);
        ticks(3);
        chk_pos("up_t4", 288, 444, 14, 2);
        ticks(16);
        chk_pos("up_t20", 288, 418, 40, 1);
        ticks(2);
        chk_pos("up_apex", 288, 418, 40, 0);

        set_st(4'b0100);
        @(negedge Clk);
        chk_pos("dn_entry", 288, 418, 40, 1);
        ticks(8);
        chk_pos("dn_t8", 288, 426, 40, 2);
        ticks(8);
        chk_pos("dn_t16", 288, 442, 40, 3);
        ticks(4);
        chk_pos("dn_t20", 288, 454, 40, 3);

        // Landing while scrolling: up_count clears, y held
        dif.is_in_middle = 1'b1;
        set_st(4'b0010);
        @(negedge Clk);
        chk_pos("land", 288, 454, 0, 4);
        ticks(3);
        chk_pos("mid_t3", 288, 454, 12, 4);

        dif.btn_left = 1'b1;
        ticks(48);
        chk("x_left_edge", 32'(dif.object_x), 32'd144);
        ticks(1);
        chk("x_wrap_left", 32'(dif.object_x), 32'd774);
        dif.btn_left  = 1'b0;
        dif.btn_right = 1'b1;
        ticks(1);
        chk("x_wrap_right", 32'(dif.object_x), 32'd144);
        ticks(1);
        chk("x_right", 32'(dif.object_x), 32'd147);
        dif.btn_left = 1'b1;
        ticks(1);
        chk_pos("both_btn", 147, 454, 40, 0);

        dif.btn_left = 1'b0;
        set_st(4'b0110);
        ticks(2);
        chk_pos("invalid", 147, 454, 40, 0);

        set_st(4'b1000);
        ticks(2);
        chk_pos("done", 147, 454, 40, 0);

        #2 Reset = 1'b1;
        #1;
        chk_pos("rst_async", 288, 458, 0, 0);
        chk("rst_async_tick", 32'(dif.frame_tick), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        dif.btn_right    = 1'b0;
        dif.is_in_middle = 1'b0;
        dif.JUMP_HEIGHT  = 10'd500;
        set_st(4'b0010);
        @(negedge Clk);
        chk("hi_entry_vs", 32'(dif.vert_speed), 32'd4);
        ticks(103);
        chk_pos("y_clamp", 288, 48, 412, 4);

        set_st(4'b0001);
        @(negedge Clk);
        chk_pos("state_i", 288, 458, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
